// File: rtl/conv2d_stride_engine_if.sv
// Handshake and bus bundle for conv2d_stride_engine; the engine takes the slave side.
// Latency: none (wiring only). Backpressure: out_ready, driven by the consumer on the master side.
// Parameters must match the engine instance they connect to.
interface conv2d_stride_engine_if #(
    parameter int IMG_SIZE  = 7,
    parameter int KER_SIZE  = 3,
    parameter int STRIDE    = 1,
    parameter int WIDTH_BIT = 8
);
    localparam int OUT_SIZE = (IMG_SIZE - KER_SIZE) / STRIDE + 1;
    localparam int OW       = $clog2(OUT_SIZE) + 1;

    logic                                              start;
    logic                                              busy;
    logic                                              out_valid;
    logic                                              out_ready;
    logic [WIDTH_BIT-1:0]                              out_data;
    logic [OW-1:0]                                     out_row;
    logic [OW-1:0]                                     out_col;
    logic                                              done;
    logic [IMG_SIZE-1:0][IMG_SIZE-1:0][WIDTH_BIT-1:0]  inpMatrixI;
    logic [KER_SIZE-1:0][KER_SIZE-1:0][WIDTH_BIT-1:0]  kernel;
    logic [OUT_SIZE-1:0][OUT_SIZE-1:0][WIDTH_BIT-1:0]  convOut;

    modport master (
        output start, inpMatrixI, kernel, out_ready,
        input  busy, out_valid, out_data, out_row, out_col, convOut, done
    );

    modport slave (
        input  start, inpMatrixI, kernel, out_ready,
        output busy, out_valid, out_data, out_row, out_col, convOut, done
    );
endinterface

// File: rtl/conv2d_stride_engine.sv
// Strided 2D convolution with one signed MAC per cycle; optional ReLU via CONV_RELU_EN.
// Latency: first output KER_SIZE^2+2 cycles after start, then one every KER_SIZE^2+1 cycles.
// Backpressure: EMIT holds out_valid/out_data/out_row/out_col stable until out_ready.
module conv2d_stride_engine #(
    parameter int IMG_SIZE  = 7,
    parameter int KER_SIZE  = 3,
    parameter int STRIDE    = 1,
    parameter int WIDTH_BIT = 8,
    parameter int ACC_BIT   = 20
) (
    input logic                    clock,
    input logic                    reset,
    conv2d_stride_engine_if.slave  bus
);
    localparam int OUT_SIZE = (IMG_SIZE - KER_SIZE) / STRIDE + 1;
    localparam int OW = $clog2(OUT_SIZE) + 1;
    localparam int IW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam int KW = (KER_SIZE > 1) ? $clog2(KER_SIZE) : 1;
    localparam int CW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KER_SIZE - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_SIZE - 1);
    localparam logic signed [ACC_BIT-1:0] SAT_HI = ACC_BIT'(2 ** (WIDTH_BIT - 1) - 1);
    localparam logic signed [ACC_BIT-1:0] SAT_LO = ~SAT_HI;

    if (ACC_BIT < 2 * WIDTH_BIT + $clog2(KER_SIZE * KER_SIZE)) begin : g_acc_too_narrow
        $error("conv2d_stride_engine: ACC_BIT too narrow for WIDTH_BIT/KER_SIZE");
    end

    typedef enum logic [2:0] {IDLE, LOAD, MAC, EMIT, DONE} state_t;

    state_t                                            state, state_nxt;
    logic [IMG_SIZE-1:0][IMG_SIZE-1:0][WIDTH_BIT-1:0]  img_q;
    logic [KER_SIZE-1:0][KER_SIZE-1:0][WIDTH_BIT-1:0]  ker_q;
    logic [OW-1:0]                                     r, c;
    logic [KW-1:0]                                     kr, kc;
    logic signed [ACC_BIT-1:0]                         acc, sum;
    logic signed [2*WIDTH_BIT-1:0]                     prod;
    logic [IW-1:0]                                     prow, pcol;
    logic [WIDTH_BIT-1:0]                              res;
    logic                                              ker_last, win_last, hs;

    assign ker_last = (kr == K_LAST) && (kc == K_LAST);
    assign win_last = (r == O_LAST) && (c == O_LAST);
    assign hs       = (state == EMIT) && bus.out_ready;

    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == EMIT);
    assign bus.done      = (state == DONE);

    // The sum is consumed in MAC only; in other states it is a don't-care.
    always_comb begin
        prow = IW'(32'(r) * 32'(STRIDE) + 32'(kr));
        pcol = IW'(32'(c) * 32'(STRIDE) + 32'(kc));
        prod = $signed(img_q[prow][pcol]) * $signed(ker_q[kr][kc]);
        sum  = acc + ACC_BIT'(prod);
        if (sum > SAT_HI) begin
            res = SAT_HI[WIDTH_BIT-1:0];
        end else if (sum < SAT_LO) begin
            res = SAT_LO[WIDTH_BIT-1:0];
        end else begin
            res = sum[WIDTH_BIT-1:0];
        end
`ifdef CONV_RELU_EN
        if (res[WIDTH_BIT-1]) begin
            res = '0;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    state_nxt = MAC;
            MAC:     if (ker_last) state_nxt = EMIT;
            EMIT:    if (hs) state_nxt = win_last ? DONE : MAC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand snapshot: later input changes never reach a run in progress.
    always_ff @(posedge clock) begin
        if (state == LOAD) begin
            img_q <= bus.inpMatrixI;
            ker_q <= bus.kernel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc          <= '0;
            r            <= '0;
            c            <= '0;
            kr           <= '0;
            kc           <= '0;
            bus.out_data <= '0;
            bus.out_row  <= '0;
            bus.out_col  <= '0;
            bus.convOut  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    acc         <= '0;
                    r           <= '0;
                    c           <= '0;
                    kr          <= '0;
                    kc          <= '0;
                    bus.convOut <= '0;
                end
                MAC: begin
                    acc <= sum;
                    if (kc == K_LAST) begin
                        kc <= '0;
                        kr <= (kr == K_LAST) ? '0 : kr + 1'b1;
                    end else begin
                        kc <= kc + 1'b1;
                    end
                    if (ker_last) begin
                        bus.out_data                      <= res;
                        bus.out_row                       <= r;
                        bus.out_col                       <= c;
                        bus.convOut[r[CW-1:0]][c[CW-1:0]] <= res;
                    end
                end
                EMIT: begin
                    if (hs && !win_last) begin
                        acc <= '0;
                        if (c == O_LAST) begin
                            c <= '0;
                            r <= r + 1'b1;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
